// File: rtl/mc_maindec.sv
// Purpose : multicycle main decoder. A Moore FSM steps one instruction through
//           FETCH..writeback and drives the datapath enables, mux selects and aluop.
// Latency : 3-5 cycles per instruction; each low mem_ready cycle in FETCH/MEMRD/MEMWR adds one.
// Backpr. : mem_ready low holds the FSM in its memory state (no PC/IR update while stalled).
//
// Ports   : clk, reset (async, active high) ; op[OP_W-1:0] from the instruction register ;
//           mem_ready memory handshake ; pcwrite, branch, iord, memwrite, irwrite, memtoreg,
//           regdst, regwrite, alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0] datapath controls ;
//           illegal (DECODE pulse on unknown op), halted (in HALT) ; branchne (BNE builds only).
// Options : `define MC_MAINDEC_BNE_EN adds opcode 000101 (BNE) and the branchne port.
//           ILLEGAL_TRAP=0 resumes at FETCH after an illegal op, 1 parks in HALT until reset.
module mc_maindec #(
   parameter int OP_W         = 6,
   parameter int ILLEGAL_TRAP = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            pcwrite,
   output logic            branch,
   output logic            iord,
   output logic            memwrite,
   output logic            irwrite,
   output logic            memtoreg,
   output logic            regdst,
   output logic            regwrite,
   output logic            alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      pcsrc,
   output logic [1:0]      aluop,
   output logic            illegal,
   output logic            halted
`ifdef MC_MAINDEC_BNE_EN
   ,output logic           branchne
`endif
);

   // Opcodes zero-extended to OP_W, so any nonzero upper bit falls to the illegal branch.
   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_MAINDEC_BNE_EN
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      HALT    = 4'd12,
      BNEX    = 4'd13
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       illegal;
      logic       halted;
`ifdef MC_MAINDEC_BNE_EN
      logic       branchne;
`endif
   } ctl_t;

   state_t state_q, state_d;
   ctl_t   ctl, ctl_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctl     = '0;
      case (state_q)
         FETCH: begin
            ctl.alusrcb = 2'b01;
            // PC and IR only advance on the cycle the fetch actually completes.
            ctl.irwrite = mem_ready;
            ctl.pcwrite = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            ctl.alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
`ifdef MC_MAINDEC_BNE_EN
               OP_BNE:       state_d = BNEX;
`endif
               default: begin
                  ctl.illegal = 1'b1;
                  state_d     = (ILLEGAL_TRAP != 0) ? HALT : FETCH;
               end
            endcase
         end
         MEMADR: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = 2'b10;
            // op is re-sampled here; anything but LW/SW abandons the access.
            if (op == OP_LW)      state_d = MEMRD;
            else if (op == OP_SW) state_d = MEMWR;
            else                  state_d = FETCH;
         end
         MEMRD: begin
            ctl.iord = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ctl.memtoreg = 1'b1;
            ctl.regwrite = 1'b1;
            state_d      = FETCH;
         end
         MEMWR: begin
            ctl.iord     = 1'b1;
            ctl.memwrite = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXECUTE: begin
            ctl.alusrca = 1'b1;
            ctl.aluop   = 2'b10;
            state_d     = ALUWB;
         end
         ALUWB: begin
            ctl.regdst   = 1'b1;
            ctl.regwrite = 1'b1;
            state_d      = FETCH;
         end
         BRANCH: begin
            ctl.alusrca = 1'b1;
            ctl.aluop   = 2'b01;
            ctl.pcsrc   = 2'b01;
            ctl.branch  = 1'b1;
            state_d     = FETCH;
         end
`ifdef MC_MAINDEC_BNE_EN
         BNEX: begin
            ctl.alusrca  = 1'b1;
            ctl.aluop    = 2'b01;
            ctl.pcsrc    = 2'b01;
            ctl.branch   = 1'b1;
            ctl.branchne = 1'b1;
            state_d      = FETCH;
         end
`endif
         ADDIEX: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = 2'b10;
            state_d     = ADDIWB;
         end
         ADDIWB: begin
            ctl.regwrite = 1'b1;
            state_d      = FETCH;
         end
         JUMP: begin
            ctl.pcsrc   = 2'b10;
            ctl.pcwrite = 1'b1;
            state_d     = FETCH;
         end
         HALT: begin
            ctl.halted = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset forces every output low combinationally, without waiting for an edge.
   assign ctl_o    = reset ? '0 : ctl;
   assign pcwrite  = ctl_o.pcwrite;
   assign branch   = ctl_o.branch;
   assign iord     = ctl_o.iord;
   assign memwrite = ctl_o.memwrite;
   assign irwrite  = ctl_o.irwrite;
   assign memtoreg = ctl_o.memtoreg;
   assign regdst   = ctl_o.regdst;
   assign regwrite = ctl_o.regwrite;
   assign alusrca  = ctl_o.alusrca;
   assign alusrcb  = ctl_o.alusrcb;
   assign pcsrc    = ctl_o.pcsrc;
   assign aluop    = ctl_o.aluop;
   assign illegal  = ctl_o.illegal;
   assign halted   = ctl_o.halted;
`ifdef MC_MAINDEC_BNE_EN
   assign branchne = ctl_o.branchne;
`endif

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM that sequences one instruction over 3–5 cycles. Drives datapath enables, mux selects and aluop (2 bits) for the ALU decoder.
- Adds memory-ready stall handshake, parametrised opcode width, and illegal-opcode detection with a selectable trap policy.
- Sits between the instruction register opcode field and the multicycle datapath.

Parameters:
- OP_W, 6, opcode field width. Must be ≥6; opcodes are compared zero-extended to OP_W.
- ILLEGAL_TRAP, 0, 0 = illegal opcode returns to FETCH; 1 = enter HALT until reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory handshake: access completes in cycles where high
- pcwrite  out  1  unconditional PC write
- branch  out  1  conditional PC write (datapath ANDs with zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  writeback select: 1 = data register
- regdst  out  1  destination select: 1 = rd
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
- illegal  out  1  one-cycle pulse in DECODE when op is unrecognised
- halted  out  1  high while in HALT

Behaviour:
- State register uses asynchronous reset to FETCH. While reset is high, every output is 0.
- All outputs are combinational from state, plus mem_ready where noted. An output not listed for a state is 0.
- Recognised opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Any upper op bits beyond 6 that are nonzero make the opcode illegal.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Go to DECODE when mem_ready, else stay (stall; no PC/IR update).
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state:
  - LW/SW → MEMADR
  - RTYPE → EXECUTE
  - BEQ → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - illegal → FETCH (ILLEGAL_TRAP=0) or HALT (=1); illegal=1 in this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Go to MEMWB when mem_ready, else stay.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1 held until mem_ready. Go to FETCH when mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next FETCH.
- HALT: halted=1, all enables 0. Self-loop; exit only via reset.
- Cycle counts with mem_ready tied high:
  - RTYPE 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3.
  - Each low mem_ready cycle in FETCH/MEMRD/MEMWR adds exactly 1 cycle.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous). After deassertion the FSM restarts in FETCH on the first clock edge.
- Unreachable state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: MC_MAINDEC_BNE_EN.
- Defined: opcode 000101 (BNE) is recognised. DECODE → BNEX, which drives the BRANCH outputs plus an extra port branchne=1. Next FETCH; 3 cycles.
- Undefined: no branchne port exists, and 000101 is illegal.

Test Plan:
- Reset held 3 cycles, released, mem_ready=1, op=000000 → all outputs 0 during reset; states FETCH,DECODE,EXECUTE,ALUWB; regwrite=1 & regdst=1 only in cycle 4; back in FETCH at cycle 5.
- op=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD → irwrite pulses once; total 10 cycles; regwrite & memtoreg high in the final cycle.
- op=101011, mem_ready=1 → memwrite=1 & iord=1 for exactly 1 cycle (cycle 4); regwrite never high.
- op=000100 then op=000010 back-to-back → BEQ: branch=1, pcsrc=01, aluop=01 in cycle 3. J: pcwrite=1, pcsrc=10 in cycle 6.
- op=111111 with ILLEGAL_TRAP=0 → illegal=1 for one cycle, FETCH next. Same with ILLEGAL_TRAP=1 → halted=1 and all enables 0 for 20 cycles, until reset.
- Reset asserted mid-cycle in MEMWB → regwrite falls without a clock edge; FSM in FETCH after release. With MC_MAINDEC_BNE_EN, op=000101 → branchne=1 in cycle 3.
